// File: rtl/ucup_ext_mem_pkg.sv
// Shared types and constants for the uCup external memory model.
package ucup_ext_mem_pkg;

    // Read data returned for any access outside the mapped window.
    localparam logic [31:0] ERR_RDATA = 32'hDEAD_BEEF;

    // Deepest response pipe the model supports.
    localparam int MAX_LATENCY = 4;

    // One stage of a per-port response pipe.
    typedef struct packed {
        logic        valid;
        logic [31:0] data;
    } resp_t;

endpackage

// File: rtl/ucup_resp_pipe.sv
// Fixed-depth response shift pipe, one instance per memory port.
// Stage 0 is loaded at the accept edge, so a response leaves the pipe
// Latency-1 edges after it entered.
module ucup_resp_pipe
    import ucup_ext_mem_pkg::*;
#(
    parameter int Latency = 1
) (
    input  logic  clk_sys_i,
    input  logic  rst_sys_i,
    input  resp_t resp_i,
    output resp_t resp_o
);

    resp_t r_stage [Latency];

    // Shift the pipe every cycle; reset flushes every in-flight response.
    // NOTE: sequential state uses non-blocking assignments so every stage
    // samples its neighbour's pre-edge value and the shift does not collapse.
    always_ff @(posedge clk_sys_i or posedge rst_sys_i) begin
        if (rst_sys_i) begin
            for (int i = 0; i < Latency; i++) begin
                r_stage[i] <= '0;
            end
        end else begin
            r_stage[0] <= resp_i;
            for (int i = 1; i < Latency; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign resp_o = r_stage[Latency-1];

endmodule

// File: rtl/ucup_ext_mem.sv
// Multi-port word-organised SRAM model for the uCup Verilated build.
// Every request is accepted; responses come back in order after Latency
// cycles. Reads are read-first, same-word writes merge per byte with the
// lowest-index port winning, out-of-range accesses set a sticky error.
// Optional feature: define UCUP_EXT_MEM_STATS_EN to get per-port
// accepted-request counters on access_cnt_o (tied to 0 otherwise).
module ucup_ext_mem
    import ucup_ext_mem_pkg::*;
#(
    parameter int          NumPorts = 2,
    parameter int          MemWords = 16384,
    parameter logic [31:0] BaseAddr = 32'h0010_0000,
    parameter int          Latency  = 1,
    parameter string       InitFile = ""
) (
    input  logic                clk_sys_i,
    input  logic                rst_sys_i,
    input  logic [NumPorts-1:0] mem_req_i,
    input  logic [NumPorts-1:0] mem_we_i,
    input  logic [3:0]          mem_be_i     [NumPorts],
    input  logic [31:0]         mem_addr_i   [NumPorts],
    input  logic [31:0]         mem_wdata_i  [NumPorts],
    output logic [NumPorts-1:0] mem_rvalid_o,
    output logic [31:0]         mem_rdata_o  [NumPorts],
    output logic                err_o,
    output logic [31:0]         access_cnt_o [NumPorts]
);

    localparam int          IdxW     = (MemWords > 1) ? $clog2(MemWords) : 1;
    localparam logic [32:0] MemBytes = 33'(MemWords) << 2;

    if (Latency < 1 || Latency > MAX_LATENCY) begin : g_bad_latency
        $error("ucup_ext_mem: Latency %0d outside 1..%0d", Latency, MAX_LATENCY);
    end

    // NOTE: the array has no reset; it models SRAM contents that must survive
    // a reset pulse, and a reset on every word would block RAM inference.
    logic [31:0]         r_mem [MemWords];

    logic [31:0]         w_off      [NumPorts];
    logic [31:0]         w_word     [NumPorts];
    logic [IdxW-1:0]     w_idx      [NumPorts];
    logic [NumPorts-1:0] w_in_range;
    logic [NumPorts-1:0] w_wr_en;
    logic                w_unused_word;
    resp_t               w_resp_in  [NumPorts];
    resp_t               w_resp_out [NumPorts];
    logic                r_err;

    // Address decode: offset from the window base, word index, range test.
    // NOTE: every always_comb output is assigned on every path, so no
    // latches can be inferred.
    always_comb begin
        w_unused_word = 1'b0;
        for (int p = 0; p < NumPorts; p++) begin
            w_off[p]      = mem_addr_i[p] - BaseAddr;
            w_word[p]     = w_off[p] >> 2;
            w_idx[p]      = w_word[p][IdxW-1:0];
            w_in_range[p] = (mem_addr_i[p] >= BaseAddr) &&
                            ({1'b0, w_off[p]} < MemBytes);
            w_wr_en[p]    = mem_req_i[p] && mem_we_i[p] && w_in_range[p];
            // Upper word-index bits are zero whenever the access is in range.
            w_unused_word = w_unused_word ^ (^w_word[p]);
        end
    end

    // Response payload captured at the accept edge (array read before write).
    always_comb begin
        for (int p = 0; p < NumPorts; p++) begin
            w_resp_in[p].valid = mem_req_i[p];
            if (!mem_req_i[p] || mem_we_i[p]) begin
                w_resp_in[p].data = '0;
            end else if (!w_in_range[p]) begin
                w_resp_in[p].data = ERR_RDATA;
            end else begin
                w_resp_in[p].data = r_mem[w_idx[p]];
            end
        end
    end

    // Byte-enabled array writes; ports are applied highest index first so the
    // lowest-index port's bytes land last and win any overlap.
    always_ff @(posedge clk_sys_i) begin
        for (int p = NumPorts - 1; p >= 0; p--) begin
            if (w_wr_en[p]) begin
                for (int b = 0; b < 4; b++) begin
                    if (mem_be_i[p][b]) begin
                        r_mem[w_idx[p]][8*b +: 8] <= mem_wdata_i[p][8*b +: 8];
                    end
                end
            end
        end
    end

    // Independent in-order response pipe per port.
    for (genvar gp = 0; gp < NumPorts; gp++) begin : g_port
        ucup_resp_pipe #(
            .Latency (Latency)
        ) u_pipe (
            .clk_sys_i (clk_sys_i),
            .rst_sys_i (rst_sys_i),
            .resp_i    (w_resp_in[gp]),
            .resp_o    (w_resp_out[gp])
        );

        assign mem_rvalid_o[gp] = w_resp_out[gp].valid;
        assign mem_rdata_o[gp]  = w_resp_out[gp].data;
    end

    // Sticky error flag: any accepted out-of-range request sets it until reset.
    always_ff @(posedge clk_sys_i or posedge rst_sys_i) begin
        if (rst_sys_i) begin
            r_err <= 1'b0;
        end else if (|(mem_req_i & ~w_in_range)) begin
            r_err <= 1'b1;
        end
    end

    assign err_o = r_err;

`ifdef UCUP_EXT_MEM_STATS_EN
    logic [31:0] r_cnt [NumPorts];

    // Per-port accepted-request counters, wrapping at 2^32.
    always_ff @(posedge clk_sys_i or posedge rst_sys_i) begin
        if (rst_sys_i) begin
            for (int p = 0; p < NumPorts; p++) begin
                r_cnt[p] <= '0;
            end
        end else begin
            for (int p = 0; p < NumPorts; p++) begin
                if (mem_req_i[p]) begin
                    r_cnt[p] <= r_cnt[p] + 32'd1;
                end
            end
        end
    end

    assign access_cnt_o = r_cnt;
`else
    assign access_cnt_o = '{default: '0};
`endif

endmodule

// File: tb/tb_ucup_ext_mem.sv
// Self-checking bench for ucup_ext_mem: three instances (Latency 1, 2, 3)
// share one stimulus stream and are compared every cycle against a
// transaction-level model of the memory and its response timing.
module tb_ucup_ext_mem;
    import ucup_ext_mem_pkg::*;

    localparam int          NP   = 2;
    localparam int          MW   = 16384;
    localparam logic [31:0] BASE = 32'h0010_0000;
    localparam int          NI   = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [NP-1:0] req, we;
    logic [3:0]    be    [NP];
    logic [31:0]   addr  [NP];
    logic [31:0]   wdata [NP];

    logic [NP-1:0] rvalid_l1, rvalid_l2, rvalid_l3;
    logic [31:0]   rdata_l1 [NP], rdata_l2 [NP], rdata_l3 [NP];
    logic          err_l1, err_l2, err_l3;
    logic [31:0]   cnt_l1 [NP], cnt_l2 [NP], cnt_l3 [NP];

    always #5 clk = ~clk;

    ucup_ext_mem #(.NumPorts(NP), .MemWords(MW), .BaseAddr(BASE), .Latency(1), .InitFile("")) u_dut_l1 (
        .clk_sys_i(clk), .rst_sys_i(rst), .mem_req_i(req), .mem_we_i(we), .mem_be_i(be),
        .mem_addr_i(addr), .mem_wdata_i(wdata), .mem_rvalid_o(rvalid_l1), .mem_rdata_o(rdata_l1),
        .err_o(err_l1), .access_cnt_o(cnt_l1));

    ucup_ext_mem #(.NumPorts(NP), .MemWords(MW), .BaseAddr(BASE), .Latency(2), .InitFile("")) u_dut_l2 (
        .clk_sys_i(clk), .rst_sys_i(rst), .mem_req_i(req), .mem_we_i(we), .mem_be_i(be),
        .mem_addr_i(addr), .mem_wdata_i(wdata), .mem_rvalid_o(rvalid_l2), .mem_rdata_o(rdata_l2),
        .err_o(err_l2), .access_cnt_o(cnt_l2));

    ucup_ext_mem #(.NumPorts(NP), .MemWords(MW), .BaseAddr(BASE), .Latency(3), .InitFile("")) u_dut_l3 (
        .clk_sys_i(clk), .rst_sys_i(rst), .mem_req_i(req), .mem_we_i(we), .mem_be_i(be),
        .mem_addr_i(addr), .mem_wdata_i(wdata), .mem_rvalid_o(rvalid_l3), .mem_rdata_o(rdata_l3),
        .err_o(err_l3), .access_cnt_o(cnt_l3));

    // ---------------- reference model ----------------
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [31:0] mdl_mem [int];      // word index -> contents
    logic [31:0] hist    [longint];  // (accept edge, port) -> response data
    bit          mdl_err;
    logic [31:0] mdl_cnt [NP];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        mdl_err = 1'b0;
        for (int p = 0; p < NP; p++) mdl_cnt[p] = '0;
    endtask

    // One rising edge of the model: record responses, then apply writes.
    task automatic model_step();
        bit          inr  [NP];
        int          widx [NP];
        longint      a;
        bit          taken;
        logic [31:0] tmp;
        cyc++;
        if (rst) return;
        for (int p = 0; p < NP; p++) begin
            inr[p]  = 1'b0;
            widx[p] = 0;
            if (req[p]) begin
                a       = longint'(addr[p]);
                inr[p]  = (a >= longint'(BASE)) && (a < longint'(BASE) + 4 * longint'(MW));
                widx[p] = inr[p] ? int'((a - longint'(BASE)) / 4) : 0;
                if (we[p])       hist[longint'(cyc) * NP + p] = 32'h0;
                else if (!inr[p]) hist[longint'(cyc) * NP + p] = 32'hDEAD_BEEF;
                else             hist[longint'(cyc) * NP + p] = mdl_mem[widx[p]];
                mdl_cnt[p] = mdl_cnt[p] + 1;
                if (!inr[p]) mdl_err = 1'b1;
            end
        end
        for (int p = 0; p < NP; p++) begin
            if (req[p] && we[p] && inr[p]) begin
                for (int b = 0; b < 4; b++) begin
                    if (be[p][b]) begin
                        taken = 1'b0;
                        for (int q = 0; q < p; q++)
                            if (req[q] && we[q] && inr[q] && widx[q] == widx[p] && be[q][b]) taken = 1'b1;
                        if (!taken) begin
                            tmp = mdl_mem[widx[p]];
                            tmp[8*b +: 8] = wdata[p][8*b +: 8];
                            mdl_mem[widx[p]] = tmp;
                        end
                    end
                end
            end
        end
    endtask

    // Compare every instance/port against the model at the falling edge.
    task automatic check_outputs();
        logic [NP-1:0] v;
        logic [31:0]   d [NP];
        logic [31:0]   c [NP];
        logic          e;
        longint        key;
        bit            ev;
        logic [31:0]   ec;
        for (int i = 0; i < NI; i++) begin
            case (i)
                0:       begin v = rvalid_l1; d = rdata_l1; c = cnt_l1; e = err_l1; end
                1:       begin v = rvalid_l2; d = rdata_l2; c = cnt_l2; e = err_l2; end
                default: begin v = rvalid_l3; d = rdata_l3; c = cnt_l3; e = err_l3; end
            endcase
            for (int p = 0; p < NP; p++) begin
                // Latency L = i+1: request at edge N shows after edge N+L-1.
                key = (longint'(cyc) - i) * NP + p;
                ev  = (cyc > i) && hist.exists(key);
                check($sformatf("L%0d_p%0d_rvalid_c%0d", i + 1, p, cyc), 32'(v[p]), 32'(ev));
                if (ev) check($sformatf("L%0d_p%0d_rdata_c%0d", i + 1, p, cyc), d[p], hist[key]);
                if (rst) check($sformatf("L%0d_p%0d_rdata_rst", i + 1, p), d[p], 32'h0);
`ifdef UCUP_EXT_MEM_STATS_EN
                ec = mdl_cnt[p];
`else
                ec = 32'h0;
`endif
                check($sformatf("L%0d_p%0d_cnt_c%0d", i + 1, p, cyc), c[p], ec);
            end
            check($sformatf("L%0d_err_c%0d", i + 1, cyc), 32'(e), 32'(mdl_err));
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle();
        for (int p = 0; p < NP; p++) begin
            req[p] = 1'b0; we[p] = 1'b0; be[p] = 4'h0; addr[p] = '0; wdata[p] = '0;
        end
    endtask

    task automatic set_rd(input int p, input logic [31:0] a);
        req[p] = 1'b1; we[p] = 1'b0; be[p] = 4'h0; addr[p] = a; wdata[p] = $urandom;
    endtask

    task automatic set_wr(input int p, input logic [31:0] a, input logic [31:0] dat, input logic [3:0] b);
        req[p] = 1'b1; we[p] = 1'b1; be[p] = b; addr[p] = a; wdata[p] = dat;
    endtask

    int          pool [8]  = '{32'h20, 32'h40, 32'h60, 32'h61, 32'h80, 32'h81, MW - 1, 32'h1000};
    logic [31:0] pre  [8]  = '{32'h0000_0013, 32'h1111_1111, 32'hCAFE_0001, 32'hCAFE_0002,
                               32'h0000_0000, 32'h5A5A_5A5A, 32'h0BAD_F00D, 32'h1234_5678};
    logic [31:0] oor  [4]  = '{32'h0000_0000, 32'h000F_FFFF, 32'h0011_0000, 32'hFFFF_FFFC};
    logic [31:0] b2b_addr [4] = '{32'h0010_0080, 32'h0010_0100, 32'h0010_0180, 32'h0010_0184};
    logic [31:0] b2b_data [4] = '{32'h0000_0013, 32'h11BB_11DD, 32'hCAFE_0001, 32'hCAFE_0002};

    initial begin
        rst = 1'b1;
        idle();
        model_reset();
        tick();
        tick();
        check("reset_rvalid_l3", 32'(rvalid_l3), 32'h0);
        rst = 1'b0;
        tick();

        // Preload the address pool, two words per cycle.
        for (int k = 0; k < 8; k += 2) begin
            set_wr(0, BASE + 32'(pool[k]) * 4, pre[k], 4'hF);
            set_wr(1, BASE + 32'(pool[k + 1]) * 4, pre[k + 1], 4'hF);
            tick();
        end
        idle();
        repeat (3) tick();

        // Basic read at Latency 1.
        set_rd(0, 32'h0010_0080);
        tick();
        check("rd_basic_rvalid", 32'(rvalid_l1[0]), 32'h1);
        check("rd_basic_rdata", rdata_l1[0], 32'h0000_0013);
        check("rd_basic_err", 32'(err_l1), 32'h0);

        // Partial write then read back.
        idle();
        set_wr(1, 32'h0010_0100, 32'hAABB_CCDD, 4'b0101);
        tick();
        check("wr_resp_rvalid", 32'(rvalid_l1[1]), 32'h1);
        check("wr_resp_rdata", rdata_l1[1], 32'h0);
        idle();
        set_rd(1, 32'h0010_0100);
        tick();
        check("wr_be_readback", rdata_l1[1], 32'h11BB_11DD);
        idle();
        repeat (3) tick();

        // Back-to-back reads on port 1, observed on the Latency 3 instance.
        for (int k = 0; k < 7; k++) begin
            idle();
            if (k < 4) set_rd(1, b2b_addr[k]);
            tick();
            if (k >= 2 && k < 6) begin
                check($sformatf("b2b_l3_rvalid_%0d", k), 32'(rvalid_l3[1]), 32'h1);
                check($sformatf("b2b_l3_rdata_%0d", k), rdata_l3[1], b2b_data[k - 2]);
            end else begin
                check($sformatf("b2b_l3_idle_%0d", k), 32'(rvalid_l3[1]), 32'h0);
            end
        end

        // Same-cycle writes merge by byte, lowest port wins overlap.
        idle();
        set_wr(0, 32'h0010_0200, 32'h0000_00AA, 4'b0001);
        set_wr(1, 32'h0010_0200, 32'hFFFF_FFFF, 4'b0011);
        tick();
        // Same-cycle read/write: read sees the pre-write word.
        idle();
        set_rd(0, 32'h0010_0200);
        set_wr(1, 32'h0010_0200, 32'h7777_7777, 4'b1000);
        tick();
        check("ww_merge_rdata", rdata_l1[0], 32'h0000_FFAA);
        idle();
        set_rd(0, 32'h0010_0202);
        tick();
        check("rw_after_rdata", rdata_l1[0], 32'h7700_FFAA);

        // Out-of-range read, dropped out-of-range write, boundary words.
        idle();
        set_rd(0, 32'h0000_0000);
        tick();
        check("oor_rdata", rdata_l1[0], ERR_RDATA);
        check("oor_err", 32'(err_l1), 32'h1);
        idle();
        set_rd(0, 32'h0010_0080);
        set_wr(1, BASE + 32'(MW) * 4, 32'hFFFF_FFFF, 4'hF);
        tick();
        check("after_oor_rdata", rdata_l1[0], 32'h0000_0013);
        check("oor_wr_resp", rdata_l1[1], 32'h0);
        idle();
        set_rd(0, BASE + 32'(MW - 1) * 4 + 32'd3);
        tick();
        check("last_word_rdata", rdata_l1[0], 32'h0BAD_F00D);
        idle();
        repeat (3) tick();
        check("err_sticky", 32'(err_l1), 32'h1);
        rst = 1'b1;
        model_reset();
        tick();
        check("err_cleared", 32'(err_l2), 32'h0);
        rst = 1'b0;
        tick();

        // Reset with reads in flight flushes them.
        set_rd(0, 32'h0010_0080);
        set_rd(1, 32'h0010_0100);
        tick();
        rst = 1'b1;
        model_reset();
        for (int k = 0; k < 2; k++) begin
            tick();
            check($sformatf("flush_l2_rst_%0d", k), 32'(rvalid_l2), 32'h0);
        end
        idle();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("flush_l2_after_%0d", k), 32'(rvalid_l2), 32'h0);
        end
        check("flush_cnt_l2", cnt_l2[0], 32'h0);

        // Randomized traffic with one mid-run reset.
        for (int k = 0; k < 600; k++) begin
            if (k == 300) begin
                idle();
                rst = 1'b1;
                model_reset();
                tick();
                rst = 1'b0;
            end
            for (int p = 0; p < NP; p++) begin
                req[p]   = ($urandom_range(3) != 0);
                we[p]    = $urandom_range(1) == 1;
                be[p]    = 4'($urandom);
                wdata[p] = $urandom;
                if ($urandom_range(9) == 0) addr[p] = oor[$urandom_range(3)];
                else addr[p] = BASE + 32'(pool[$urandom_range(7)]) * 4 + 32'($urandom_range(3));
            end
            tick();
        end
        idle();
        repeat (4) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
